// File: rtl/cdma_rx_decoder.sv
// cdma_rx_decoder: despreads one port's CDMA code out of the aggregated per-chip sums.
// Optional CDMA_RX_CHECK_EN adds chk_err_o, flagging final sums off the ideal T +/- N/2 points.
module cdma_rx_decoder #(
    parameter int CODE_WIDTH = 8,
    parameter int CODE_ID    = 1,
    parameter int DATA_WIDTH = 1,
    parameter int SUM_W      = $clog2(CODE_WIDTH + 1),
    parameter int ACC_W      = $clog2(CODE_WIDTH * CODE_WIDTH + 1) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH*SUM_W-1:0] chip_sum_i,
    input  logic                        chip_valid_i,
    input  logic                        sync_i,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic                        data_valid_o,
    input  logic                        data_ready_i,
    output logic                        frame_abort_o,
    output logic                        ovf_o
`ifdef CDMA_RX_CHECK_EN
    ,
    output logic [DATA_WIDTH-1:0]       chk_err_o
`endif
);
    // Code table rows are Walsh sequences: chip k of code id is parity(id & ~k).
    function automatic logic [CODE_WIDTH-1:0] gen_code(input int id);
        logic [CODE_WIDTH-1:0] c;
        c = '0;
        for (int k = 0; k < CODE_WIDTH; k++) c[k] = ^(id & ~k & (CODE_WIDTH - 1));
        return c;
    endfunction

    function automatic int count_ones(input logic [CODE_WIDTH-1:0] c);
        int n;
        n = 0;
        for (int k = 0; k < CODE_WIDTH; k++) n += int'(c[k]);
        return n;
    endfunction

    localparam int CNT_W = (CODE_WIDTH > 1) ? $clog2(CODE_WIDTH) : 1;
    localparam logic [CODE_WIDTH-1:0] CODE = gen_code(CODE_ID);
    localparam int ONES = count_ones(CODE);
    localparam int THR = CODE_WIDTH * (CODE_WIDTH - 2 * ONES) / 2;
    localparam logic signed [ACC_W-1:0] T_A = ACC_W'(THR);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(CODE_WIDTH / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CODE_WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q [DATA_WIDTH];
    logic signed [ACC_W-1:0] acc_d [DATA_WIDTH];
    logic signed [ACC_W-1:0] term  [DATA_WIDTH];
    logic [DATA_WIDTH-1:0]   data_q, data_d, dec;
    logic                    valid_q, valid_d, abort_q, abort_d, ovf_q, ovf_d;
    logic                    run, load, take, last, c_k;
`ifdef CDMA_RX_CHECK_EN
    logic [DATA_WIDTH-1:0]   chk_q, chk_d, chk;
`endif

    always_comb begin
        run     = state_q == RUN;
        load    = chip_valid_i && (run ? (sync_i || cnt_q == '0) : sync_i);
        take    = chip_valid_i && (run || sync_i);
        last    = chip_valid_i && run && !sync_i && cnt_q == LAST;
        abort_d = chip_valid_i && run && sync_i && cnt_q != '0;
        c_k     = CODE[load ? '0 : cnt_q];
        dec     = '0;
`ifdef CDMA_RX_CHECK_EN
        chk     = '0;
`endif
        for (int l = 0; l < DATA_WIDTH; l++) begin
            term[l]  = ACC_W'(chip_sum_i[l*SUM_W +: SUM_W]);
            term[l]  = c_k ? -term[l] : term[l];
            acc_d[l] = !take ? acc_q[l] : load ? term[l] : acc_q[l] + term[l];
            dec[l]   = acc_d[l] > T_A;
`ifdef CDMA_RX_CHECK_EN
            chk[l]   = acc_d[l] != T_A + HALF && acc_d[l] != T_A - HALF;
`endif
        end
        state_d = load ? RUN : state_q;
        cnt_d   = load ? CNT_W'(1) : take ? (cnt_q == LAST ? '0 : cnt_q + 1'b1) : cnt_q;
        data_d  = last ? dec : data_q;
        valid_d = last || (valid_q && !data_ready_i);
        ovf_d   = ovf_q || (last && valid_q && !data_ready_i);
`ifdef CDMA_RX_CHECK_EN
        chk_d   = last ? chk : chk_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '{default: '0};
            data_q  <= '0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef CDMA_RX_CHECK_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            abort_q <= abort_d;
            ovf_q   <= ovf_d;
`ifdef CDMA_RX_CHECK_EN
            chk_q   <= chk_d;
`endif
        end
    end

    assign data_o        = data_q;
    assign data_valid_o  = valid_q;
    assign frame_abort_o = abort_q;
    assign ovf_o         = ovf_q;
`ifdef CDMA_RX_CHECK_EN
    assign chk_err_o     = chk_q;
`endif
endmodule

// File: tb/tb_cdma_rx_decoder.sv
// tb_cdma_rx_decoder: two decoders (code 1 and code 0) fed by the same aggregated chips,
// checked every cycle against a symbol-level correlation model plus literal anchors.
module tb_cdma_rx_decoder;
    localparam int N  = 8;
    localparam int DW = 2;
    localparam int SW = 4;
    localparam bit [7:0] CODES [8] = '{8'h00, 8'h55, 8'h33, 8'h66, 8'h0F, 8'h5A, 8'h3C, 8'h69};
    localparam int IDS [2] = '{1, 0};

    logic clk = 0;
    logic rst = 1;
    logic [DW*SW-1:0] chip_sum = '0;
    logic chip_valid = 0, sync = 0, ready = 1;
    logic [DW-1:0] dut_data [2];
    logic dut_valid [2];
    logic dut_abort [2];
    logic dut_ovf [2];
`ifdef CDMA_RX_CHECK_EN
    logic [DW-1:0] dut_chk [2];
`endif

    int n_chk = 0, n_fail = 0;
    bit rnd_ready = 0;

    always #5 clk = ~clk;

    cdma_rx_decoder #(.CODE_WIDTH(N), .CODE_ID(1), .DATA_WIDTH(DW)) u0 (
        .clk(clk), .rst(rst), .chip_sum_i(chip_sum), .chip_valid_i(chip_valid), .sync_i(sync),
        .data_o(dut_data[0]), .data_valid_o(dut_valid[0]), .data_ready_i(ready),
        .frame_abort_o(dut_abort[0]), .ovf_o(dut_ovf[0])
`ifdef CDMA_RX_CHECK_EN
        , .chk_err_o(dut_chk[0])
`endif
    );

    cdma_rx_decoder #(.CODE_WIDTH(N), .CODE_ID(0), .DATA_WIDTH(DW)) u1 (
        .clk(clk), .rst(rst), .chip_sum_i(chip_sum), .chip_valid_i(chip_valid), .sync_i(sync),
        .data_o(dut_data[1]), .data_valid_o(dut_valid[1]), .data_ready_i(ready),
        .frame_abort_o(dut_abort[1]), .ovf_o(dut_ovf[1])
`ifdef CDMA_RX_CHECK_EN
        , .chk_err_o(dut_chk[1])
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int thr(input int ci);
        return N * (N - 2 * $countones(CODES[ci])) / 2;
    endfunction

    // Number of the eight transmitters whose chip k is 1 when port p sends d[p].
    function automatic int ssum(input bit [7:0] d, input int k);
        int n = 0;
        for (int p = 0; p < 8; p++) n += int'(d[p] ^ CODES[p][k]);
        return n;
    endfunction

    function automatic int ideal_acc(input int ci, input bit [7:0] d);
        int a = 0;
        for (int k = 0; k < N; k++) a += CODES[ci][k] ? -ssum(d, k) : ssum(d, k);
        return a;
    endfunction

    // Symbol-level reference: collect a symbol's chip sums, correlate once complete.
    int m_s [2][N][DW];
    int m_len [2];
    bit m_started [2];
    logic [DW-1:0] m_data [2];
    logic [DW-1:0] m_chk [2];
    bit m_valid [2], m_abort [2], m_ovf [2];
    bit go = 0;
    bit dec_now;
    logic [DW-1:0] dec, chk;
    int acc;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_abort[i] = 0;
            dec_now = 0;
            if (rst) begin
                m_started[i] = 0; m_len[i] = 0; m_data[i] = '0; m_chk[i] = '0;
                m_valid[i] = 0; m_ovf[i] = 0;
            end else begin
                if (chip_valid && (m_started[i] || sync)) begin
                    if (m_started[i] && sync && m_len[i] != 0) m_abort[i] = 1;
                    if (sync) m_len[i] = 0;
                    m_started[i] = 1;
                    for (int l = 0; l < DW; l++) m_s[i][m_len[i]][l] = int'(chip_sum[l*SW +: SW]);
                    m_len[i]++;
                    if (m_len[i] == N) begin
                        m_len[i] = 0;
                        dec_now = 1;
                        for (int l = 0; l < DW; l++) begin
                            acc = 0;
                            for (int k = 0; k < N; k++) acc += CODES[IDS[i]][k] ? -m_s[i][k][l] : m_s[i][k][l];
                            dec[l] = acc > thr(IDS[i]);
                            chk[l] = acc != thr(IDS[i]) + N / 2 && acc != thr(IDS[i]) - N / 2;
                        end
                    end
                end
                if (dec_now) begin
                    if (m_valid[i] && !ready) m_ovf[i] = 1;
                    m_data[i] = dec;
                    m_chk[i] = chk;
                    m_valid[i] = 1;
                end else if (ready) m_valid[i] = 0;
            end
        end
        go = 1;
    end

    always @(negedge clk) begin
        if (go) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d valid", i), 32'(dut_valid[i]), 32'(m_valid[i]));
                check($sformatf("u%0d abort", i), 32'(dut_abort[i]), 32'(m_abort[i]));
                check($sformatf("u%0d ovf", i), 32'(dut_ovf[i]), 32'(m_ovf[i]));
                if (m_valid[i]) check($sformatf("u%0d data", i), 32'(dut_data[i]), 32'(m_data[i]));
`ifdef CDMA_RX_CHECK_EN
                if (m_valid[i]) check($sformatf("u%0d chk", i), 32'(dut_chk[i]), 32'(m_chk[i]));
`endif
            end
        end
    end

    task automatic drive(input bit v, input bit s, input logic [DW*SW-1:0] sum);
        chip_valid = v;
        sync = s;
        chip_sum = sum;
        if (rnd_ready) ready = 1'($urandom);
        @(negedge clk);
    endtask

    task automatic symbol(input bit [7:0] d0, input bit [7:0] d1, input bit sy, input int stall_at,
                          input int stall_len, input int noise_k, input int from, input int cut);
        int s0, s1;
        for (int k = from; k < cut; k++) begin
            if (k == stall_at) repeat (stall_len) drive(0, 1'($urandom), 8'($urandom));
            s0 = ssum(d0, k) + int'(k == noise_k);
            s1 = ssum(d1, k);
            drive(1, sy && k == from, {SW'(s1), SW'(s0)});
        end
        chip_valid = 0;
        sync = 0;
    endtask

    initial begin
        @(negedge clk);
        check("pin acc code1 idle", ideal_acc(1, 8'h00), -4);
        check("pin acc code1 port1", ideal_acc(1, 8'h02), 4);
        check("pin acc code0 port0", ideal_acc(0, 8'h01), 36);
        check("pin acc code0 idle", ideal_acc(0, 8'h00), 28);
        check("pin thr code1", thr(1), 0);
        check("pin thr code0", thr(0), 32);
        repeat (2) @(negedge clk);
        check("reset valid", 32'(dut_valid[0]), 0);
        check("reset data", 32'(dut_data[0]), 0);
        rst = 0;
        symbol(8'h00, 8'h00, 1, -1, 0, -1, 0, N);
        check("t1 valid", 32'(dut_valid[0]), 1);
        check("t1 data", 32'(dut_data[0]), 0);
        check("t1 code0 data", 32'(dut_data[1]), 0);
        symbol(8'h02, 8'h02, 1, -1, 0, -1, 0, N);
        check("t2 data", 32'(dut_data[0]), 3);
        symbol(8'h02, 8'h00, 0, -1, 0, -1, 0, N);
        check("t2 b2b data", 32'(dut_data[0]), 1);
        symbol(8'h01, 8'h00, 1, -1, 0, -1, 0, N);
        check("t3 code0 data", 32'(dut_data[1]), 1);
        symbol(8'h00, 8'h00, 1, 4, 3, -1, 0, N);
        check("t4 stalled data", 32'(dut_data[0]), 0);
        check("t4 stalled valid", 32'(dut_valid[0]), 1);
        symbol(8'hFF, 8'h00, 1, -1, 0, -1, 0, 5);
        ready = 0;
        symbol(8'h00, 8'h00, 1, -1, 0, -1, 0, 1);
        check("t5 abort pulse", 32'(dut_abort[0]), 1);
        symbol(8'h00, 8'h00, 0, -1, 0, -1, 1, N);
        check("t5 no ovf yet", 32'(dut_ovf[0]), 0);
        symbol(8'h02, 8'h02, 0, -1, 0, -1, 0, N);
        check("t5 ovf", 32'(dut_ovf[0]), 1);
        check("t5 second word", 32'(dut_data[0]), 3);
        ready = 1;
        symbol(8'h02, 8'h02, 1, -1, 0, 3, 0, N);
        check("t6 noisy data", 32'(dut_data[0]), 3);
`ifdef CDMA_RX_CHECK_EN
        check("t6 noisy chk", 32'(dut_chk[0]), 1);
`endif
        symbol(8'h02, 8'h02, 0, -1, 0, -1, 0, N);
`ifdef CDMA_RX_CHECK_EN
        check("t6 clean chk", 32'(dut_chk[0]), 0);
`endif
        symbol(8'h5A, 8'h00, 1, -1, 0, -1, 0, 4);
        rst = 1;
        drive(0, 0, '0);
        rst = 0;
        check("rst mid abort", 32'(dut_abort[0]), 0);
        check("rst mid ovf", 32'(dut_ovf[0]), 0);
        symbol(8'h02, 8'h00, 0, -1, 0, -1, 4, N);
        check("idle ignores", 32'(dut_valid[0]), 0);
        rnd_ready = 1;
        repeat (200) begin
            symbol(8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1) : -1, $urandom_range(1, 3),
                   ($urandom_range(0, 4) == 0) ? $urandom_range(0, N - 1) : -1, 0,
                   ($urandom_range(0, 7) == 0) ? $urandom_range(1, N - 1) : N);
            if ($urandom_range(0, 2) == 0) drive(0, 0, '0);
        end
        rnd_ready = 0;
        ready = 1;
        repeat (3) drive(0, 0, '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
